// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths: default rates,
// the transmitter state encoding and the serial line idle level.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 100_000_000;
  localparam int unsigned BAUD_DEFAULT     = 9600;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Truncating divide; choosing a rate pair that divides cleanly is up to the integrator.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_word_tx.sv
// 16-bit word UART transmitter: sends each word as two back-to-back 8N1 frames,
// high byte first, each byte LSB first, with the serial line driven from a flop.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD         = BAUD_DEFAULT,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] TxWord,
  input  logic        TxValid,
  output logic        TxReady,
  output logic        TxData,
  output logic        TxBusy,
  output logic        TxDone
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_word_tx: CLKS_PER_BIT must be at least 2");
  end

  tx_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]       r_bit, w_bit_nxt, w_bit_inc;
  logic             r_idx, w_idx_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_done, w_done_nxt;
  logic [15:0]      r_word;
  logic [7:0]       w_byte;
  logic             w_bit_end;
  logic             w_accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_idx   <= 1'b0;
      r_tx    <= LINE_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Holding register is data only; it is always reloaded on accept before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_word <= TxWord;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_idx_nxt   = r_idx;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    w_byte      = r_idx ? r_word[7:0] : r_word[15:8];
    w_bit_inc   = r_bit + 3'd1;
    w_bit_end   = (r_baud == LAST_CNT);

    if (r_state != IDLE) begin
      w_baud_nxt = w_bit_end ? '0 : r_baud + CNT_W'(1);
    end

    case (r_state)
      IDLE: begin
        w_tx_nxt   = LINE_IDLE;
        w_baud_nxt = '0;
        if (TxValid) begin
          w_accept    = 1'b1;
          w_state_nxt = START;
          w_idx_nxt   = 1'b0;
          w_tx_nxt    = ~LINE_IDLE;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = w_byte[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = LINE_IDLE;
          end else begin
            w_bit_nxt = w_bit_inc;
            w_tx_nxt  = w_byte[w_bit_inc];
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          // High byte done: the low byte's start bit follows with no idle gap.
          if (!r_idx) begin
            w_state_nxt = START;
            w_idx_nxt   = 1'b1;
            w_tx_nxt    = ~LINE_IDLE;
          end else begin
            w_state_nxt = IDLE;
            w_idx_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
            w_tx_nxt    = LINE_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = LINE_IDLE;
      end
    endcase
  end

  assign TxData  = r_tx;
  assign TxReady = (r_state == IDLE);
  assign TxBusy  = ~TxReady;
  assign TxDone  = r_done;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: a frame-level line model checked every cycle, plus
// directed words decoded at mid-bit against hand-computed values.
module tb_uart_word_tx;

  localparam int C = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] TxWord = 16'h0000;
  logic        TxValid = 1'b0;
  logic        TxReady, TxData, TxBusy, TxDone;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_acc = 0;
  int done_cnt = 0;

  uart_word_tx #(.CLKS_PER_BIT(C)) dut (
    .clk    (clk),
    .reset  (reset),
    .TxWord (TxWord),
    .TxValid(TxValid),
    .TxReady(TxReady),
    .TxData (TxData),
    .TxBusy (TxBusy),
    .TxDone (TxDone)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (TxDone === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line image of one word: bit 0 is the first bit on the wire.
  function automatic logic [19:0] frame_of(input logic [15:0] w);
    return {1'b1, w[7:0], 1'b0, 1'b1, w[15:8], 1'b0};
  endfunction

  // Model: a word occupies the line for 20*C cycles after its accept edge.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_k = 0;
  logic [15:0] m_word = 16'h0000;

  always @(posedge clk or posedge reset) begin
    m_done = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_k = m_k + 1;
      if (m_k == 20 * C) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (TxValid === 1'b1) begin
      m_busy = 1'b1;
      m_k    = 0;
      m_word = TxWord;
    end
  end

  always @(negedge clk) begin
    logic [19:0] fr;
    logic        exp_line;
    fr = frame_of(m_word);
    exp_line = m_busy ? fr[m_k / C] : 1'b1;
    chk("model_TxData",  TxData,  exp_line);
    chk("model_TxReady", TxReady, !m_busy);
    chk("model_TxBusy",  TxBusy,  m_busy);
    chk("model_TxDone",  TxDone,  m_done);
  end

  task automatic send(input logic [15:0] w);
    int n = 0;
    while (TxReady !== 1'b1 && n < 30 * C) begin @(negedge clk); n++; end
    chk("send_ready_seen", TxReady, 1'b1);
    TxWord  = w;
    TxValid = 1'b1;
    @(posedge clk); #1;
    t_acc = cyc;
    @(negedge clk);
    TxValid = 1'b0;
  endtask

  task automatic rx_word(input string tag, output logic [15:0] w);
    int n = 0;
    logic [7:0] b;
    w = 16'h0000;
    b = 8'h00;
    while (TxData !== 1'b0 && n < 40 * C) begin @(negedge clk); n++; end
    chk({tag, "_start_seen"}, TxData, 1'b0);
    repeat (C / 2) @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      chk({tag, "_startbit"}, TxData, 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        b[i] = TxData;
      end
      repeat (C) @(negedge clk);
      chk({tag, "_stopbit"}, TxData, 1'b1);
      if (f == 0) begin
        w[15:8] = b;
        repeat (C) @(negedge clk);
      end else begin
        w[7:0] = b;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (TxDone !== 1'b1 && n < 30 * C) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, TxDone, 1'b1);
    chk({tag, "_latency"}, 32'(cyc - t_acc), 32'd320);
  endtask

  initial begin
    logic [15:0] w;
    int bad;
    int d0;

    chk("model_frame_20F2", frame_of(16'h20F2), 20'hF9240);

    // Reset held, then released; line must stay idle.
    repeat (5) @(negedge clk);
    chk("rst_TxData",  TxData,  1'b1);
    chk("rst_TxReady", TxReady, 1'b1);
    chk("rst_TxBusy",  TxBusy,  1'b0);
    chk("rst_TxDone",  TxDone,  1'b0);
    reset = 1'b0;
    bad = 0;
    repeat (50000) begin
      @(negedge clk);
      if (TxData !== 1'b1 || TxBusy !== 1'b0) bad++;
    end
    chk("idle_after_reset", bad, 0);

    // Single word.
    send(16'h20F2);
    rx_word("w20F2", w);
    chk("w20F2_hi", w[15:8], 8'h20);
    chk("w20F2_lo", w[7:0],  8'hF2);
    wait_done("w20F2");
    repeat (3) @(negedge clk);

    // Back-to-back with TxValid held high.
    TxWord  = 16'h0064;
    TxValid = 1'b1;
    @(posedge clk); #1;
    t_acc = cyc;
    @(negedge clk);
    TxWord = 16'h00C8;
    rx_word("b2b_first", w);
    chk("b2b_first_word", w, 16'h0064);
    wait_done("b2b_first");
    chk("b2b_ready_in_done", TxReady, 1'b1);
    @(posedge clk); #1;
    t_acc = cyc;
    @(negedge clk);
    chk("b2b_start_no_gap", TxData, 1'b0);
    chk("b2b_busy", TxBusy, 1'b1);
    TxValid = 1'b0;
    rx_word("b2b_second", w);
    chk("b2b_second_word", w, 16'h00C8);
    wait_done("b2b_second");
    repeat (3) @(negedge clk);

    // Busy rejection: new word and pulse mid-frame must be ignored.
    d0 = done_cnt;
    send(16'h1104);
    fork
      rx_word("busy", w);
      begin
        repeat (5 * C) @(negedge clk);
        TxWord  = 16'hFFFF;
        TxValid = 1'b1;
        @(negedge clk);
        TxValid = 1'b0;
      end
    join
    chk("busy_word", w, 16'h1104);
    wait_done("busy");
    repeat (3 * C) @(negedge clk);
    chk("busy_single_done", done_cnt - d0, 1);

    // Reset during the high byte's DATA state.
    d0 = done_cnt;
    send(16'h00FF);
    repeat (3 * C) @(negedge clk);
    chk("pre_reset_line_low", TxData, 1'b0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_reset_TxData",  TxData,  1'b1);
    chk("async_reset_TxReady", TxReady, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (25 * C) @(negedge clk);
    chk("reset_no_done", done_cnt - d0, 0);
    send(16'h03E8);
    rx_word("after_reset", w);
    chk("after_reset_word", w, 16'h03E8);
    wait_done("after_reset");
    repeat (3) @(negedge clk);

    // Loopback sweep 100..1000.
    for (int v = 100; v <= 1000; v += 100) begin
      send(16'(v));
      rx_word("loop", w);
      chk("loop_word", w, 32'(v));
      wait_done("loop");
      repeat (2) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
